// File: rtl/prescale_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : prescale_seq                                               |
// | Purpose  : Run controller for a prescaled counter. A 1..P inner        |
// |            prescaler advances a 0..W outer counter once per period;    |
// |            finite runs end after R outer wraps with a done pulse,      |
// |            R=0 runs continuously until stop.                           |
// | Revision : 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module prescale_seq #(
  parameter int PW = 3,
  parameter int CW = 2,
  parameter int RW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] cfg_pre,
  input  logic [CW-1:0] cfg_wrap,
  input  logic [RW-1:0] cfg_runs,
  input  logic          start,
  input  logic          stop,
  output logic          busy,
  output logic          tick,
  output logic [CW-1:0] cnt,
  output logic          wrap,
  output logic          done
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [PW-1:0] C_ONE_P = PW'(1);
  localparam logic [RW-1:0] C_ONE_R = RW'(1);

  state_t        state_q, state_d;
  logic [PW-1:0] icnt_q, icnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [CW-1:0] wlim_q, wlim_d;
  logic [RW-1:0] runs_q, runs_d;
  logic [RW-1:0] runs_left_q, runs_left_d;
  logic          done_q, done_d;

  logic          w_busy;
  logic          w_tick;
  logic          w_wrap;

  // Output decodes; a coincident stop suppresses the tick (and so the wrap)
  always_comb begin
    w_busy = (state_q == ST_RUN);
    w_tick = w_busy && (icnt_q == pre_q) && !stop;
    w_wrap = w_tick && (cnt_q == wlim_q);
  end

  assign busy = w_busy;
  assign tick = w_tick;
  assign wrap = w_wrap;
  assign cnt  = cnt_q;
  assign done = done_q;

  // Next-state logic: configuration latch, inner/outer counting, run termination
  always_comb begin
    state_d     = state_q;
    icnt_d      = icnt_q;
    cnt_d       = cnt_q;
    pre_d       = pre_q;
    wlim_d      = wlim_q;
    runs_d      = runs_q;
    runs_left_d = runs_left_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // stop beats a coincident start
        if (start && !stop) begin
          pre_d       = (cfg_pre == '0) ? C_ONE_P : cfg_pre;
          wlim_d      = cfg_wrap;
          runs_d      = cfg_runs;
          runs_left_d = cfg_runs;
          icnt_d      = C_ONE_P;
          cnt_d       = '0;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
          icnt_d  = C_ONE_P;
          cnt_d   = '0;
        end else begin
          icnt_d = w_tick ? C_ONE_P : icnt_q + C_ONE_P;
          if (w_tick) begin
            if (w_wrap) begin
              cnt_d = '0;
              // runs_q == 0 means continuous: never self-terminate
              if (runs_q != '0) begin
                if (runs_left_q == C_ONE_R) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
                  icnt_d  = C_ONE_P;
                end else begin
                  runs_left_d = runs_left_q - C_ONE_R;
                end
              end
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      icnt_q      <= C_ONE_P;
      cnt_q       <= '0;
      pre_q       <= C_ONE_P;
      wlim_q      <= '0;
      runs_q      <= '0;
      runs_left_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      icnt_q      <= icnt_d;
      cnt_q       <= cnt_d;
      pre_q       <= pre_d;
      wlim_q      <= wlim_d;
      runs_q      <= runs_d;
      runs_left_q <= runs_left_d;
      done_q      <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prescale_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_prescale_seq                                            |
// | Purpose  : Scoreboard bench for prescale_seq against a cycle-count     |
// |            reference model of the run controller.                      |
// | Revision : 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module tb_prescale_seq;

  localparam int PW = 3;
  localparam int CW = 2;
  localparam int RW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] cfg_pre;
  logic [CW-1:0] cfg_wrap;
  logic [RW-1:0] cfg_runs;
  logic          start;
  logic          stop;
  logic          busy;
  logic          tick;
  logic [CW-1:0] cnt;
  logic          wrap;
  logic          done;

  prescale_seq #(.PW(PW), .CW(CW), .RW(RW)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_pre  (cfg_pre),
    .cfg_wrap (cfg_wrap),
    .cfg_runs (cfg_runs),
    .start    (start),
    .stop     (stop),
    .busy     (busy),
    .tick     (tick),
    .cnt      (cnt),
    .wrap     (wrap),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit busy;
    bit tick;
    bit wrap;
    bit done;
    int cnt;
    int cyc;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: a run is described by the number of cycles t spent in
  // it so far (t=1 is the first RUN cycle); everything else is arithmetic.
  bit m_run  = 1'b0;
  bit m_done = 1'b0;
  int m_t = 0;
  int m_p = 1;
  int m_w = 0;
  int m_r = 0;
  int cyc = 0;

  int vectors     = 0;
  int miscompares = 0;

  // Drive one cycle of inputs, queue the expected outputs, advance the model
  task automatic step(input bit r, input bit s, input bit sp,
                      input int pre, input int w, input int runs);
    exp_t e;
    int   n;
    bit   tk;
    bit   wr;
    rst      = r;
    start    = s;
    stop     = sp;
    cfg_pre  = PW'(pre);
    cfg_wrap = CW'(w);
    cfg_runs = RW'(runs);

    tk = m_run && ((m_t % m_p) == 0) && !sp;
    n  = m_run ? (m_t / m_p) : 0;
    wr = tk && ((n % (m_w + 1)) == 0);
    e.busy = m_run;
    e.tick = tk;
    e.wrap = wr;
    e.done = m_done;
    e.cnt  = m_run ? (((m_t - 1) / m_p) % (m_w + 1)) : 0;
    e.cyc  = cyc;
    exp_q.push_back(e);

    if (r) begin
      m_run  = 1'b0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_run) begin
        if (sp) begin
          m_run = 1'b0;
        end else if (wr && (m_r != 0) && ((n / (m_w + 1)) == m_r)) begin
          m_run  = 1'b0;
          m_done = 1'b1;
        end else begin
          m_t++;
        end
      end else if (s && !sp) begin
        m_run = 1'b1;
        m_t   = 1;
        m_p   = (pre % 8 == 0) ? 1 : (pre % 8);
        m_w   = w % 4;
        m_r   = runs % 256;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  // Monitor: every cycle the DUT presents a result, compare it with the queue head
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      if (busy !== e.busy || tick !== e.tick || wrap !== e.wrap ||
          done !== e.done || cnt !== CW'(e.cnt)) begin
        miscompares++;
        $display("FAIL outputs cyc=%0d got busy=%b tick=%b cnt=%0d wrap=%b done=%b expected busy=%b tick=%b cnt=%0d wrap=%b done=%b",
                 e.cyc, busy, tick, cnt, wrap, done,
                 e.busy, e.tick, e.cnt, e.wrap, e.done);
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    cfg_pre = '0; cfg_wrap = '0; cfg_runs = '0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 1'b0, 0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 0, 0, 0);
    idle(20);

    // P=5, W=2, R=1 single finite run
    step(1'b0, 1'b1, 1'b0, 5, 2, 1);
    idle(20);

    // P=5, W=3 continuous, then stop
    step(1'b0, 1'b1, 1'b0, 5, 3, 0);
    idle(39);
    step(1'b0, 1'b0, 1'b1, 0, 0, 0);
    idle(5);

    // cfg_pre=0, W=0, R=3: tick and wrap every RUN cycle
    step(1'b0, 1'b1, 1'b0, 0, 0, 3);
    idle(6);

    // start and stop together in IDLE
    step(1'b0, 1'b1, 1'b1, 2, 1, 1);
    idle(4);

    // stop coincident with the final wrap (P=2, W=1, R=1 wraps at t=4)
    step(1'b0, 1'b1, 1'b0, 2, 1, 1);
    idle(3);
    step(1'b0, 1'b0, 1'b1, 0, 0, 0);
    idle(4);

    // start and cfg changes during RUN are ignored
    step(1'b0, 1'b1, 1'b0, 3, 1, 2);
    for (int i = 0; i < 14; i++) step(1'b0, (i % 3) == 0, 1'b0, 7, 3, 9);
    idle(4);

    // reset mid-run, then a fresh run reproduces the single-run timing
    step(1'b0, 1'b1, 1'b0, 5, 2, 1);
    idle(7);
    step(1'b1, 1'b0, 1'b0, 0, 0, 0);
    idle(2);
    step(1'b0, 1'b1, 1'b0, 5, 2, 1);
    idle(18);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 128) == 0, ($urandom % 6) == 0, ($urandom % 40) == 0,
           int'($urandom % 8), int'($urandom % 4), int'($urandom % 4));
    end
    idle(3);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending expected 0 pending", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
